param_reg_file: RTL and testbench

//  Parametrised multi-read-port integer register file for the RISC-V core. It replaces the fixed
//  2-read/1-write Register_File and its shared REG_RD_WRN strobe.
//  - Separate write and read enables, registered reads with write-first bypass.
//  - Optional hardwired-zero x0.
//  - Per-register busy scoreboard: decode sets a bit at issue, write-back clears it.
//  - Sits between decode (read and issue side) and write-back (write side).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 57 +++++
 rtl/param_reg_file.sv | 83 ++++++++
 tb/tb_param_reg_file.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the integer register file and its busy scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_XLEN   = 32;
  localparam int unsigned DEF_NREGS  = 32;
  localparam int unsigned DEF_NUM_RD = 2;

  // Address width for n registers, never less than 1 bit.
  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set at issue, cleared at write-back, looked up by each read port.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned NREGS    = DEF_NREGS,
  parameter  int unsigned ZERO_REG = 1,
  parameter  int unsigned NUM_RD   = DEF_NUM_RD,
  localparam int unsigned AW       = addr_width(NREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 set_en_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic                 clr_en_i,
  input  logic [AW-1:0]        clr_addr_i,
  input  logic [NUM_RD-1:0]    rd_en_i,
  input  logic [NUM_RD*AW-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  output logic                 any_busy_o
);

  logic [NREGS-1:0]  busy_q, busy_d, busy_clr;
  logic [NUM_RD-1:0] rd_busy_q, rd_busy_d;
  logic              any_busy_q;
  logic              zero_clr, zero_set;

  assign zero_clr = (ZERO_REG != 0) && (clr_addr_i == '0);
  assign zero_set = (ZERO_REG != 0) && (set_addr_i == '0);

  // Lookups see the vector after this cycle's clear but before this cycle's set.
  always_comb begin
    busy_clr = busy_q;
    if (clr_en_i && !zero_clr) busy_clr[clr_addr_i] = 1'b0;
    busy_d = busy_clr;
    if (set_en_i && !zero_set) busy_d[set_addr_i] = 1'b1;
    rd_busy_d = rd_busy_q;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_en_i[p]) rd_busy_d[p] = busy_clr[rd_addr_i[p*AW +: AW]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      rd_busy_q  <= '0;
      any_busy_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      rd_busy_q  <= rd_busy_d;
      any_busy_q <= |busy_d;
    end
  end

  assign rd_busy_o  = rd_busy_q;
  assign any_busy_o = any_busy_q;

endmodule

// File: rtl/param_reg_file.sv
// Parametrised multi-read-port integer register file with write-first bypass,
// optional hardwired-zero x0 and a per-register busy scoreboard.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN     = DEF_XLEN,
  parameter  int unsigned NREGS    = DEF_NREGS,
  parameter  int unsigned NUM_RD   = DEF_NUM_RD,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = addr_width(NREGS)
) (
  input  logic                   CK_REF,
  input  logic                   RST,
  input  logic                   WR_EN,
  input  logic [AW-1:0]          WR_ADDR,
  input  logic [XLEN-1:0]        WR_DATA,
  input  logic [NUM_RD-1:0]      RS_EN,
  input  logic [NUM_RD*AW-1:0]   RS_ADDR,
  output logic [NUM_RD*XLEN-1:0] RS_DATA,
  output logic [NUM_RD-1:0]      RS_BUSY,
  input  logic                   ISSUE_EN,
  input  logic [AW-1:0]          ISSUE_RD,
  output logic                   ANY_BUSY,
  input  logic [AW-1:0]          DBG_ADDR,
  output logic [XLEN-1:0]        DBG_DATA
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_ok;

  assign wr_ok = WR_EN && !((ZERO_REG != 0) && (WR_ADDR == '0));

  always_ff @(posedge CK_REF) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[WR_ADDR] <= WR_DATA;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data_d, data_q;

    assign addr = RS_ADDR[p*AW +: AW];

    always_comb begin
      data_d = data_q;
      if (RS_EN[p]) begin
        if ((ZERO_REG != 0) && (addr == '0)) data_d = '0;
        else if (WR_EN && (WR_ADDR == addr)) data_d = WR_DATA;
        else                                  data_d = mem_q[addr];
      end
    end

    always_ff @(posedge CK_REF) begin
      if (RST) data_q <= '0;
      else     data_q <= data_d;
    end

    assign RS_DATA[p*XLEN +: XLEN] = data_q;
  end

  assign DBG_DATA = mem_q[DBG_ADDR];

  reg_scoreboard #(
    .NREGS   (NREGS),
    .ZERO_REG(ZERO_REG),
    .NUM_RD  (NUM_RD)
  ) u_sb (
    .clk_i     (CK_REF),
    .rst_i     (RST),
    .set_en_i  (ISSUE_EN),
    .set_addr_i(ISSUE_RD),
    .clr_en_i  (WR_EN),
    .clr_addr_i(WR_ADDR),
    .rd_en_i   (RS_EN),
    .rd_addr_i (RS_ADDR),
    .rd_busy_o (RS_BUSY),
    .any_busy_o(ANY_BUSY)
  );

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file (XLEN=64, 4 read ports, hardwired x0): expected outputs are
// queued as each cycle is driven and compared after the edge that produces them.
module tb_param_reg_file;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NRD  = 4;
  localparam int unsigned AW   = 5;

  logic                  CK_REF = 1'b0;
  logic                  RST = 1'b1;
  logic                  WR_EN = 1'b0;
  logic [AW-1:0]         WR_ADDR = '0;
  logic [XLEN-1:0]       WR_DATA = '0;
  logic [NRD-1:0]        RS_EN = '0;
  logic [NRD*AW-1:0]     RS_ADDR = '0;
  logic [NRD*XLEN-1:0]   RS_DATA;
  logic [NRD-1:0]        RS_BUSY;
  logic                  ISSUE_EN = 1'b0;
  logic [AW-1:0]         ISSUE_RD = '0;
  logic                  ANY_BUSY;
  logic [AW-1:0]         DBG_ADDR = '0;
  logic [XLEN-1:0]       DBG_DATA;

  param_reg_file #(
    .XLEN    (XLEN),
    .NREGS   (32),
    .NUM_RD  (NRD),
    .ZERO_REG(1)
  ) dut (
    .CK_REF  (CK_REF),
    .RST     (RST),
    .WR_EN   (WR_EN),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .RS_EN   (RS_EN),
    .RS_ADDR (RS_ADDR),
    .RS_DATA (RS_DATA),
    .RS_BUSY (RS_BUSY),
    .ISSUE_EN(ISSUE_EN),
    .ISSUE_RD(ISSUE_RD),
    .ANY_BUSY(ANY_BUSY),
    .DBG_ADDR(DBG_ADDR),
    .DBG_DATA(DBG_DATA)
  );

  always #5 CK_REF = ~CK_REF;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct {
    string       tag;
    int          sel;   // 0..3 data port, 4..7 busy port, 8 ANY_BUSY
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];

  // Behavioural reference state
  logic [63:0] m_mem [32];
  logic [31:0] m_busy;
  logic [63:0] m_rs  [4];
  logic        m_rsb [4];
  logic        m_any;

  function automatic logic [63:0] observe(input int sel);
    if (sel < 4)      return RS_DATA[sel*64 +: 64];
    else if (sel < 8) return {63'd0, RS_BUSY[sel-4]};
    else              return {63'd0, ANY_BUSY};
  endfunction

  task automatic step(input bit rst, input bit we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [3:0] en, input logic [4:0] a0, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] a3,
                      input bit ie, input logic [4:0] ird, input logic [4:0] dbg);
    logic [4:0] ad [4];
    exp_t e;
    ad = '{a0, a1, a2, a3};
    RST = rst; WR_EN = we; WR_ADDR = wa; WR_DATA = wd; RS_EN = en;
    RS_ADDR = {a3, a2, a1, a0}; ISSUE_EN = ie; ISSUE_RD = ird; DBG_ADDR = dbg;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_busy = '0; m_any = 1'b0;
      for (int p = 0; p < 4; p++) begin m_rs[p] = '0; m_rsb[p] = 1'b0; end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (en[p]) begin
          if (ad[p] == 5'd0)                 m_rs[p] = '0;
          else if (we && wa == ad[p])        m_rs[p] = wd;
          else                               m_rs[p] = m_mem[ad[p]];
          m_rsb[p] = (we && wa == ad[p]) ? 1'b0 : m_busy[ad[p]];
        end
      end
      if (we && wa != 5'd0) m_mem[wa] = wd;
      if (we) m_busy[wa] = 1'b0;
      if (ie && ird != 5'd0) m_busy[ird] = 1'b1;
      m_any = |m_busy;
    end
    for (int p = 0; p < 4; p++) begin
      e.tag = $sformatf("rs_data%0d", p); e.sel = p;     e.exp = m_rs[p];          exp_q.push_back(e);
      e.tag = $sformatf("rs_busy%0d", p); e.sel = p + 4; e.exp = {63'd0, m_rsb[p]}; exp_q.push_back(e);
    end
    e.tag = "any_busy"; e.sel = 8; e.exp = {63'd0, m_any}; exp_q.push_back(e);
    @(posedge CK_REF); #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, observe(e.sel), e.exp);
    end
    chk("dbg_data", DBG_DATA, m_mem[dbg]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, then sweep every register on all ports
    step(1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 8; c++)
      step(0, 0, 0, 0, 4'hF, 5'(4*c), 5'(4*c+1), 5'(4*c+2), 5'(4*c+3), 0, 0, 5'(c));
    for (int p = 0; p < 2; p++) chk("sweep_zero", observe(p), 64'd0);

    // 2: x0 ignores writes, x1 reads back
    step(0, 1, 0, 64'hFFFF_FFFF, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_const", RS_DATA[63:0], 64'd0);
    step(0, 1, 1, 64'hA5A5_0001, 4'h0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 4'h1, 1, 0, 0, 0, 0, 0, 1);
    chk("x1_const", RS_DATA[63:0], 64'hA5A5_0001);

    // 3: same-cycle bypass to two ports
    step(0, 1, 5, 64'h1234_5678, 4'h3, 5, 5, 0, 0, 0, 0, 5);
    chk("byp_p0", RS_DATA[63:0], 64'h1234_5678);
    chk("byp_p1", RS_DATA[127:64], 64'h1234_5678);

    // 4: scoreboard set / clear / set-wins
    step(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 7, 7);
    step(0, 0, 0, 0, 4'h1, 7, 0, 0, 0, 0, 0, 7);
    chk("busy7_set", {63'd0, RS_BUSY[0]}, 64'd1);
    chk("any_set", {63'd0, ANY_BUSY}, 64'd1);
    step(0, 1, 7, 64'hDEAD_BEEF, 4'h1, 7, 0, 0, 0, 0, 0, 7);
    chk("busy7_wb", {63'd0, RS_BUSY[0]}, 64'd0);
    chk("any_wb", {63'd0, ANY_BUSY}, 64'd0);
    step(0, 1, 7, 64'h0000_0777, 4'h0, 0, 0, 0, 0, 1, 7, 7);
    step(0, 0, 0, 0, 4'h1, 7, 0, 0, 0, 0, 0, 7);
    chk("busy7_setwins", {63'd0, RS_BUSY[0]}, 64'd1);
    step(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1, 0, 0);
    chk("issue_x0_any", {63'd0, ANY_BUSY}, 64'd1);

    // 5: four ports, distinct values, then port 2 disabled holds
    for (int r = 1; r <= 4; r++)
      step(0, 1, 5'(r), {32'hC0DE_0000 + 32'(r), 32'h0BAD_F00D ^ 32'(r)}, 4'h0, 0, 0, 0, 0, 0, 0, 5'(r));
    step(0, 0, 0, 0, 4'hF, 1, 2, 3, 4, 0, 0, 3);
    chk("p2_val", RS_DATA[191:128], {32'hC0DE_0003, 32'h0BAD_F00E});
    step(0, 0, 0, 0, 4'hB, 4, 3, 1, 2, 0, 0, 3);
    chk("p2_hold", RS_DATA[191:128], {32'hC0DE_0003, 32'h0BAD_F00E});

    // 6: write + issue, then reset beats a concurrent write/issue/read
    step(0, 1, 9, 64'h9999_AAAA_BBBB_CCCC, 4'h0, 0, 0, 0, 0, 1, 9, 9);
    step(1, 1, 9, 64'h1111_2222_3333_4444, 4'hF, 9, 9, 9, 9, 1, 9, 9);
    chk("rst_dbg9", DBG_DATA, 64'd0);
    chk("rst_any", {63'd0, ANY_BUSY}, 64'd0);
    step(0, 0, 0, 0, 4'hF, 9, 7, 5, 1, 0, 0, 9);

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
           {$urandom, $urandom}, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
